// File: rtl/router_pkg.sv
// Shared constants for the Router1x3 datapath: byte width, header field
// positions and the reserved destination address.
package router_pkg;

  localparam int DATA_WIDTH = 8;

  localparam int LEN_MSB  = DATA_WIDTH - 1;
  localparam int LEN_LSB  = 2;
  localparam int ADDR_MSB = 1;
  localparam int ADDR_LSB = 0;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

endpackage

// File: rtl/router_parity_chk.sv
// Per-packet integrity checker: running XOR parity, payload byte count,
// captured parity byte and the parity_done / err flags returned to the FSM.
module router_parity_chk
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = router_pkg::DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic                  rst_int_reg,
  input  logic                  low_pkt_valid,
  input  logic [DATA_WIDTH-1:0] header,
  input  logic [DATA_WIDTH-1:0] hold_byte,
  output logic                  parity_done,
  output logic                  err
);

  // Length field top bit follows an overridden byte width.
  localparam int LEN_TOP = LEN_MSB + (DATA_WIDTH - router_pkg::DATA_WIDTH);
  localparam int CNT_W   = LEN_TOP - LEN_LSB + 1;

  logic [DATA_WIDTH-1:0] int_parity;
  logic [DATA_WIDTH-1:0] pkt_parity;
  logic [CNT_W-1:0]      byte_cnt;
  logic [CNT_W-1:0]      header_len;
  logic                  take_din_parity;
  logic                  take_hold_parity;
  logic                  cnt_inc;

  assign header_len       = header[LEN_TOP:LEN_LSB];
  assign take_din_parity  = ld_state & ~fifo_full & ~pkt_valid;
  assign take_hold_parity = laf_state & low_pkt_valid & ~parity_done;
  // A byte replayed from hold_byte is payload unless it was the parity byte.
  assign cnt_inc = (ld_state & pkt_valid & ~fifo_full) |
                   (laf_state & ~parity_done & ~low_pkt_valid);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      int_parity <= '0;
      byte_cnt   <= '0;
    end else if (detect_add) begin
      int_parity <= '0;
      byte_cnt   <= '0;
    end else begin
      if (lfd_state)
        int_parity <= int_parity ^ header;
      else if (ld_state && pkt_valid && !full_state)
        int_parity <= int_parity ^ data_in;
      if (cnt_inc && byte_cnt != '1)
        byte_cnt <= byte_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pkt_parity  <= '0;
      parity_done <= 1'b0;
    end else begin
      if (take_din_parity)
        pkt_parity <= data_in;
      else if (take_hold_parity)
        pkt_parity <= hold_byte;
      if (take_din_parity || take_hold_parity)
        parity_done <= 1'b1;
      else if (detect_add)
        parity_done <= 1'b0;
    end
  end

  // err is held until the next packet header so the FSM can sample it late.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      err <= 1'b0;
    else if (detect_add)
      err <= 1'b0;
    else if (rst_int_reg && parity_done)
      err <= (int_parity != pkt_parity) || (byte_cnt != header_len);
  end

endmodule

// File: rtl/router_reg.sv
// Router1x3 datapath register stage: header latch, full-FIFO hold byte,
// dout steering and low_pkt_valid, with the parity checker alongside.
module router_reg
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = router_pkg::DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic                  rst_int_reg,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  parity_done,
  output logic                  low_pkt_valid,
  output logic                  err
);

  logic [DATA_WIDTH-1:0] header;
  logic [DATA_WIDTH-1:0] hold_byte;
  logic                  header_en;

  assign header_en = detect_add & pkt_valid &
                     (data_in[ADDR_MSB:ADDR_LSB] != ADDR_INVALID);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      header    <= '0;
      hold_byte <= '0;
    end else begin
      if (header_en)
        header <= data_in;
      if (ld_state && fifo_full)
        hold_byte <= data_in;
    end
  end

  // A byte arriving against a full FIFO leaves dout alone; it is replayed later.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      dout <= '0;
    else if (lfd_state)
      dout <= header;
    else if (ld_state) begin
      if (!fifo_full)
        dout <= data_in;
    end else if (laf_state)
      dout <= hold_byte;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      low_pkt_valid <= 1'b0;
    else if (ld_state && !pkt_valid)
      low_pkt_valid <= 1'b1;
    else if (rst_int_reg)
      low_pkt_valid <= 1'b0;
  end

  router_parity_chk #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity_chk (
    .clock        (clock),
    .resetn       (resetn),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .detect_add   (detect_add),
    .lfd_state    (lfd_state),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .rst_int_reg  (rst_int_reg),
    .low_pkt_valid(low_pkt_valid),
    .header       (header),
    .hold_byte    (hold_byte),
    .parity_done  (parity_done),
    .err          (err)
  );

endmodule
